// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the CPU / PS/2 memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_PS2 = 1'b1
  } req_id_t;

  localparam int unsigned AW_DEF       = 10;
  localparam int unsigned DW_DEF       = 16;
  localparam int unsigned MAX_HOLD_DEF = 4;

  function automatic req_id_t other_req(input req_id_t r);
    return (r == REQ_CPU) ? REQ_PS2 : REQ_CPU;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_hold_picker.sv
// Round-robin winner selection with a bounded hold window; owns last_win/hold_cnt.
module rr_hold_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    cpu_req,
  input  logic    ps2_req,
  output logic    gnt_any,
  output req_id_t winner
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  req_id_t       last_win, last_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;

  // hold_cnt == 0 means no current owner, so a tie goes round-robin to the
  // requester that did not win last; this is what hands the first tie to the CPU.
  always_comb begin
    gnt_any  = cpu_req | ps2_req;
    winner   = REQ_CPU;
    hold_nxt = '0;
    last_nxt = last_win;
    if (cpu_req && ps2_req) begin
      if ((hold_cnt != '0) && (hold_cnt < HOLD_MAX)) winner = last_win;
      else                                           winner = other_req(last_win);
    end else if (ps2_req) begin
      winner = REQ_PS2;
    end
    if (gnt_any) begin
      if (winner == last_win) begin
        hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
      end else begin
        hold_nxt = HW'(1);
        last_nxt = winner;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_win <= REQ_PS2;
      hold_cnt <= '0;
    end else begin
      last_win <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port synchronous RAM between the CPU and the PS/2 writer.
// Optional saturating statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          ps2_req,
  input  logic          ps2_we,
  input  logic [AW-1:0] ps2_addr,
  input  logic [DW-1:0] ps2_wdata,
  output logic          cpu_gnt,
  output logic          ps2_gnt,
  output logic          cpu_rvalid,
  output logic          ps2_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_cpu_cnt,
  output logic [CNT_W-1:0] stat_ps2_cnt,
  output logic [CNT_W-1:0] stat_conflict_cnt
`endif
);

  logic       gnt_any;
  req_id_t    winner;
  logic [1:0] rd_pend;

  rr_hold_picker #(.MAX_HOLD(MAX_HOLD)) u_picker (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_req (cpu_req),
    .ps2_req (ps2_req),
    .gnt_any (gnt_any),
    .winner  (winner)
  );

  // Grants are masked while reset is held so every output sits at its reset value.
  always_comb begin
    cpu_gnt   = rst_n & gnt_any & (winner == REQ_CPU);
    ps2_gnt   = rst_n & gnt_any & (winner == REQ_PS2);
    mem_en    = cpu_gnt | ps2_gnt;
    mem_we    = ps2_gnt ? ps2_we : (cpu_gnt & cpu_we);
    mem_addr  = ps2_gnt ? ps2_addr  : cpu_addr;
    mem_wdata = ps2_gnt ? ps2_wdata : cpu_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend <= '0;
    else        rd_pend <= {ps2_gnt & ~ps2_we, cpu_gnt & ~cpu_we};
  end

  assign cpu_rvalid = rd_pend[REQ_CPU];
  assign ps2_rvalid = rd_pend[REQ_PS2];
  assign rdata      = mem_rdata;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cpu_cnt      <= '0;
      stat_ps2_cnt      <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (cpu_gnt && (stat_cpu_cnt != '1)) stat_cpu_cnt <= stat_cpu_cnt + 1'b1;
      if (ps2_gnt && (stat_ps2_cnt != '1)) stat_ps2_cnt <= stat_ps2_cnt + 1'b1;
      if (cpu_req && ps2_req && (stat_conflict_cnt != '1))
        stat_conflict_cnt <= stat_conflict_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_HOLD=4 main DUT, MAX_HOLD=1 side DUT).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, ps2_req, ps2_we;
  logic [9:0]  cpu_addr, ps2_addr;
  logic [15:0] cpu_wdata, ps2_wdata;
  logic        cpu_gnt, ps2_gnt, cpu_rvalid, ps2_rvalid;
  logic [15:0] rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        a_cpu_gnt, a_ps2_gnt, a_cpu_rvalid, a_ps2_rvalid;
  logic [15:0] a_rdata, a_mem_wdata;
  logic        a_mem_en, a_mem_we;
  logic [9:0]  a_mem_addr;
  logic [15:0] a_mem_rdata = 16'h0000;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_cpu_cnt, stat_ps2_cnt, stat_conflict_cnt;
  logic [15:0] a_stat_cpu, a_stat_ps2, a_stat_conf;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] ram [0:1023];

  always #5 clk = ~clk;

  // Behavioural 1Kx16 synchronous RAM
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  mem_port_arbiter #(.AW(10), .DW(16), .MAX_HOLD(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ps2_req(ps2_req), .ps2_we(ps2_we), .ps2_addr(ps2_addr), .ps2_wdata(ps2_wdata),
    .cpu_gnt(cpu_gnt), .ps2_gnt(ps2_gnt), .cpu_rvalid(cpu_rvalid), .ps2_rvalid(ps2_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_cpu_cnt(stat_cpu_cnt), .stat_ps2_cnt(stat_ps2_cnt),
    .stat_conflict_cnt(stat_conflict_cnt)
`endif
  );

  mem_port_arbiter #(.AW(10), .DW(16), .MAX_HOLD(1), .CNT_W(16)) u_alt (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ps2_req(ps2_req), .ps2_we(ps2_we), .ps2_addr(ps2_addr), .ps2_wdata(ps2_wdata),
    .cpu_gnt(a_cpu_gnt), .ps2_gnt(a_ps2_gnt), .cpu_rvalid(a_cpu_rvalid),
    .ps2_rvalid(a_ps2_rvalid), .rdata(a_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .stat_cpu_cnt(a_stat_cpu), .stat_ps2_cnt(a_stat_ps2), .stat_conflict_cnt(a_stat_conf)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 16'(i);
    ram[5] = 16'hBEEF;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ps2_req = 1'b0; ps2_we = 1'b0; ps2_addr = '0; ps2_wdata = '0;

    #12;
    check_eq("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    check_eq("rst_ps2_gnt", {31'd0, ps2_gnt}, 32'd0);
    check_eq("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check_eq("rst_ps2_rvalid", {31'd0, ps2_rvalid}, 32'd0);
    check_eq("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lone CPU read of address 5
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
    #1;
    check_eq("rd_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    check_eq("rd_ps2_gnt", {31'd0, ps2_gnt}, 32'd0);
    check_eq("rd_mem_en", {31'd0, mem_en}, 32'd1);
    check_eq("rd_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("rd_mem_addr", {22'd0, mem_addr}, 32'h005);
    tick();
    cpu_req = 1'b0;
    check_eq("rd_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check_eq("rd_rdata", {16'd0, rdata}, 32'hBEEF);
    check_eq("rd_ps2_rvalid", {31'd0, ps2_rvalid}, 32'd0);
    tick();
    check_eq("rd_rvalid_drop", {31'd0, cpu_rvalid}, 32'd0);

    // PS/2 write 0x001C @0x3FF, then CPU read of the same address
    ps2_req = 1'b1; ps2_we = 1'b1; ps2_addr = 10'h3FF; ps2_wdata = 16'h001C;
    #1;
    check_eq("wr_ps2_gnt", {31'd0, ps2_gnt}, 32'd1);
    check_eq("wr_mem_we", {31'd0, mem_we}, 32'd1);
    check_eq("wr_mem_addr", {22'd0, mem_addr}, 32'h3FF);
    check_eq("wr_mem_wdata", {16'd0, mem_wdata}, 32'h001C);
    tick();
    ps2_req = 1'b0; ps2_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF;
    #1;
    check_eq("raw_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    check_eq("raw_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("raw_no_ps2_rvalid", {31'd0, ps2_rvalid}, 32'd0);
    tick();
    cpu_req = 1'b0;
    check_eq("raw_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check_eq("raw_rdata", {16'd0, rdata}, 32'h001C);
    check_eq("raw_ps2_rvalid", {31'd0, ps2_rvalid}, 32'd0);
    tick();

    // Alternating lone requests, one cycle each
    cpu_req = 1'b1; cpu_addr = 10'h001;
    #1;
    check_eq("alt0_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    tick();
    check_eq("alt0_hold", 32'(u_dut.u_picker.hold_cnt), 32'd1);
    cpu_req = 1'b0; ps2_req = 1'b1; ps2_we = 1'b0; ps2_addr = 10'h002;
    #1;
    check_eq("alt1_ps2_gnt", {31'd0, ps2_gnt}, 32'd1);
    tick();
    check_eq("alt1_hold", 32'(u_dut.u_picker.hold_cnt), 32'd1);
    check_eq("alt1_last_ps2", 32'(u_dut.u_picker.last_win), 32'd1);
    ps2_req = 1'b0; cpu_req = 1'b1;
    #1;
    check_eq("alt2_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    tick();
    check_eq("alt2_hold", 32'(u_dut.u_picker.hold_cnt), 32'd1);
    check_eq("alt2_last_cpu", 32'(u_dut.u_picker.last_win), 32'd0);
    cpu_req = 1'b0;
    tick();

    // Asynchronous reset in the cycle after a read grant
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
    tick();
    cpu_req = 1'b0;
    check_eq("mid_rvalid_pre", {31'd0, cpu_rvalid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rvalid_rst", {31'd0, cpu_rvalid}, 32'd0);
    check_eq("mid_mem_en_rst", {31'd0, mem_en}, 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h010;
    ps2_req = 1'b1; ps2_we = 1'b1; ps2_addr = 10'h020;
    #1;
    check_eq("mid_gnt_in_rst", {30'd0, cpu_gnt, ps2_gnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Continuous contention: MAX_HOLD=4 gives CPUx4, PS2x4; MAX_HOLD=1 alternates
    for (int i = 0; i < 12; i++) begin
      check_eq($sformatf("cont%0d_cpu", i), {31'd0, cpu_gnt}, ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("cont%0d_ps2", i), {31'd0, ps2_gnt}, ((i / 4) % 2 == 0) ? 32'd0 : 32'd1);
      check_eq($sformatf("alt%0d_cpu", i), {31'd0, a_cpu_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("cont%0d_rvalid", i), {31'd0, cpu_rvalid}, 32'd0);
      tick();
    end

`ifdef MEM_ARB_STATS_EN
    check_eq("stat_conflict", {16'd0, stat_conflict_cnt}, 32'd12);
    check_eq("stat_cpu", {16'd0, stat_cpu_cnt}, 32'd8);
    check_eq("stat_ps2", {16'd0, stat_ps2_cnt}, 32'd4);
    ps2_req = 1'b0;
    repeat (65539) @(posedge clk);
    #2;
    check_eq("stat_cpu_sat", {16'd0, stat_cpu_cnt}, 32'h0000FFFF);
    check_eq("stat_conflict_hold", {16'd0, stat_conflict_cnt}, 32'd12);
`endif

    cpu_req = 1'b0; ps2_req = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-port 1K×16 instruction/data memory between the accumulator CPU and the PS/2 scan-code writer. It sits between both masters and the synchronous RAM, granting at most one access per cycle. Policy is round-robin with a bounded hold window. It returns read data to the correct requester one cycle after the grant.

## Interface
- AW, 10, address width
- DW, 16, data width
- MAX_HOLD, 4, max consecutive grants to one requester while the other waits (≥1)
- CNT_W, 16, statistics counter width (used only with MEM_ARB_STATS_EN)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- cpu_req / ps2_req  in  1  access request, held until granted
- cpu_we / ps2_we  in  1  1 = write, 0 = read
- cpu_addr / ps2_addr  in  AW  address
- cpu_wdata / ps2_wdata  in  DW  write data
- cpu_gnt / ps2_gnt  out  1  request accepted this cycle (combinational)
- cpu_rvalid / ps2_rvalid  out  1  rdata valid for that requester (registered)
- rdata  out  DW  read data, passed from mem_rdata
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  AW; mem_wdata  out  DW
- mem_rdata  in  DW  RAM output, valid one cycle after mem_en & !mem_we
- stat_cpu_cnt, stat_ps2_cnt, stat_conflict_cnt  out  CNT_W  (only with MEM_ARB_STATS_EN)

## Operation
- State: last_win (0 = CPU, 1 = PS/2), hold_cnt (0..MAX_HOLD), rd_pend[1:0].
- Only one requester active: it is granted.
- Both active: the owner (last_win) keeps the grant while hold_cnt < MAX_HOLD. Otherwise the other requester wins.
- Hold counting:
  - Grant to the same requester as last_win: hold_cnt increments, saturating at MAX_HOLD.
  - Grant to a different requester: hold_cnt = 1 and last_win flips.
  - No grant: hold_cnt = 0 and last_win is unchanged.
- Memory command in a grant cycle: mem_en = 1, and the winner's we/addr/wdata are muxed to the memory port. With no grant, mem_en = 0, mem_we = 0, and addr/wdata hold the CPU inputs.
- Read grant: rd_pend[winner] is set for the next cycle. That cycle, <winner>_rvalid = 1 and rdata = mem_rdata.
- Write grant: no rvalid is produced.
- Requesters deassert req after gnt or present the next request. Back-to-back grants to the same requester are permitted every cycle.

## Timing
- Grant latency 0 cycles. Read data latency exactly 1 cycle after gnt. Throughput 1 access/cycle.
- Reset values:
  - All gnt, rvalid, mem_en, and mem_we = 0; rdata = mem_rdata passthrough.
  - last_win = 1, so the CPU wins the first tie; hold_cnt = 0; rd_pend = 0; stats = 0.
- Reset asserted mid-read: the pending rvalid is cleared immediately and not delivered after release.
- The gnt outputs depend combinationally on req and registered state only. No path from mem_rdata to gnt.
- MAX_HOLD = 1 gives strict alternation under continuous contention.
- Simultaneous write and read to the same address in consecutive cycles: RAM ordering is preserved. A read granted after a write returns the new data.

## Configuration
- MEM_ARB_STATS_EN defined:
  - stat_cpu_cnt and stat_ps2_cnt increment on each grant to that requester.
  - stat_conflict_cnt increments each cycle both reqs are high.
  - All three saturate at all-ones and reset to 0.
- Undefined: the three ports and their counters are absent. Arbitration behaviour is identical.

## Structure
- Shared package mem_arb_pkg: requester-id typedef (REQ_CPU = 0, REQ_PS2 = 1), AW/DW defaults, MAX_HOLD default.
- One sub-module, rr_hold_picker: last_win/hold_cnt registers and winner selection. The top level does muxing, rd_pend, and stats.

## Test plan
- Reset, then cpu_req read @0x005 only → cpu_gnt same cycle, mem_addr = 0x005, mem_we = 0; next cycle cpu_rvalid = 1, rdata = RAM[5]; ps2 signals stay 0.
- Both req continuously, MAX_HOLD = 4 → grants CPU×4, PS2×4, CPU×4…; first grant to CPU; stat_conflict_cnt = cycle count (stats build).
- ps2 write 0x001C @0x3FF then cpu read @0x3FF next cycle → mem_we = 1 then 0; cpu_rvalid carries 0x001C; no ps2_rvalid.
- Alternating lone requests CPU, PS2, CPU, 1 cycle each → each granted immediately; hold_cnt = 1 after each.
- Reset pulse (rst_n low, async, mid-cycle) during the cycle after a read grant → cpu_rvalid drops immediately; all outputs at reset values; first tie after release goes to CPU.
- Stats build, force 2^16+3 CPU grants → stat_cpu_cnt saturates at 0xFFFF.
